// File: rtl/pll_ctrl.sv
// pll_ctrl: Gowin rPLL dynamic-configuration sequencer (reset hold, divider selects, lock qualification).
// Optional PLL_CTRL_RETRY_EN: a lock timeout re-enters HOLD up to MAX_RETRY times before ERR.
module pll_ctrl #(
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_STABLE  = 1024,
  parameter int         LOCK_TIMEOUT = 270000,
`ifdef PLL_CTRL_RETRY_EN
  parameter int         MAX_RETRY    = 3,
`endif
  parameter logic [5:0] DEF_IDSEL    = 6'd0,
  parameter logic [5:0] DEF_FBDSEL   = 6'd0,
  parameter logic [5:0] DEF_ODSEL    = 6'd0
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       cfg_req,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  output logic       cfg_ack,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       clk_ready,
  output logic       lock_lost,
  output logic       pll_error
);

  localparam int HOLD_W = $clog2(RST_CYCLES) + 1;
  localparam int STAB_W = $clog2(LOCK_STABLE) + 1;
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_WAIT  = 3'd1,
    S_STAB  = 3'd2,
    S_READY = 3'd3,
    S_ERR   = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_tmo_state;
  logic                r_lock_p0;
  logic                r_lock_p1;
  logic                w_lock_s;
  logic                w_timeout;
  logic                w_accept;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [STAB_W-1:0]   r_stab_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                r_pll_reset;
  logic                r_clk_ready;
  logic                r_cfg_ack;
  logic                r_lock_lost;
  logic                r_pll_error;
  logic [5:0]          r_idsel;
  logic [5:0]          r_fbdsel;
  logic [5:0]          r_odsel;

  // Counters stop at their terminal value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous LOCK input.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_lock_p0 <= 1'b0;
      r_lock_p1 <= 1'b0;
    end else begin
      r_lock_p0 <= pll_lock;
      r_lock_p1 <= r_lock_p0;
    end
  end

  assign w_lock_s  = r_lock_p1;
  assign w_timeout = (r_tmo_cnt == TMO_LAST);
  assign w_accept  = ((r_state == S_READY) || (r_state == S_ERR)) && cfg_req;

`ifdef PLL_CTRL_RETRY_EN
  localparam int               ATT_W   = $clog2(MAX_RETRY) + 1;
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_RETRY);
  logic [ATT_W-1:0]            r_attempt;

  always_comb begin
    w_tmo_state = S_ERR;
    if (r_attempt < ATT_MAX) w_tmo_state = S_HOLD;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_attempt <= '0;
    end else if (w_accept || ((r_state == S_READY) && (w_state_nxt == S_HOLD))) begin
      r_attempt <= '0;
    end else if (((r_state == S_WAIT) || (r_state == S_STAB)) && (w_state_nxt == S_HOLD)) begin
      r_attempt <= ATT_W'(sat_inc(32'(r_attempt), 32'(MAX_RETRY)));
    end
  end
`else
  assign w_tmo_state = S_ERR;
`endif

  always_ff @(posedge clkin) begin
    if (reset) r_state <= S_HOLD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HOLD:  if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_timeout)     w_state_nxt = w_tmo_state;
        else if (w_lock_s) w_state_nxt = S_STAB;
      end
      // A lock that qualifies on the same cycle the timeout expires still counts.
      S_STAB: begin
        if (w_lock_s && (r_stab_cnt == STAB_LAST)) w_state_nxt = S_READY;
        else if (w_timeout)                        w_state_nxt = w_tmo_state;
        else if (!w_lock_s)                        w_state_nxt = S_WAIT;
      end
      S_READY: begin
        if (cfg_req)        w_state_nxt = S_ACK;
        else if (!w_lock_s) w_state_nxt = S_HOLD;
      end
      S_ERR:   if (cfg_req) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_HOLD;
      default: w_state_nxt = S_HOLD;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_stab_cnt <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_hold_cnt <= (r_state == S_HOLD) ?
                    HOLD_W'(sat_inc(32'(r_hold_cnt), 32'(RST_CYCLES))) : '0;
      r_stab_cnt <= ((r_state == S_STAB) && w_lock_s) ?
                    STAB_W'(sat_inc(32'(r_stab_cnt), 32'(LOCK_STABLE))) : '0;
      r_tmo_cnt  <= ((r_state == S_WAIT) || (r_state == S_STAB)) ?
                    TMO_W'(sat_inc(32'(r_tmo_cnt), 32'(LOCK_TIMEOUT))) : '0;
    end
  end

  // Outputs registered from the next state; ACK keeps the PLL in reset when leaving ERR.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_pll_reset <= 1'b1;
      r_clk_ready <= 1'b0;
      r_cfg_ack   <= 1'b0;
      r_lock_lost <= 1'b0;
      r_pll_error <= 1'b0;
      r_idsel     <= DEF_IDSEL;
      r_fbdsel    <= DEF_FBDSEL;
      r_odsel     <= DEF_ODSEL;
    end else begin
      r_pll_reset <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_ERR) ||
                     ((w_state_nxt == S_ACK) && (r_state == S_ERR));
      r_clk_ready <= (w_state_nxt == S_READY);
      r_cfg_ack   <= w_accept;
      r_lock_lost <= (r_state == S_READY) && (w_state_nxt == S_HOLD);
      r_pll_error <= (w_state_nxt == S_ERR);
      if (w_accept) begin
        r_idsel  <= cfg_idsel;
        r_fbdsel <= cfg_fbdsel;
        r_odsel  <= cfg_odsel;
      end
    end
  end

  assign pll_reset  = r_pll_reset;
  assign clk_ready  = r_clk_ready;
  assign cfg_ack    = r_cfg_ack;
  assign lock_lost  = r_lock_lost;
  assign pll_error  = r_pll_error;
  assign pll_idsel  = r_idsel;
  assign pll_fbdsel = r_fbdsel;
  assign pll_odsel  = r_odsel;

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: directed scenarios for pll_ctrl with RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=2.
module tb_pll_ctrl;

  localparam logic [5:0] D_ID = 6'd1;
  localparam logic [5:0] D_FB = 6'd2;
  localparam logic [5:0] D_OD = 6'd4;
`ifdef PLL_CTRL_RETRY_EN
  localparam int EXP_TMO_STEPS = 308;  // 3 waits of 100 plus 2 holds of 4
  localparam int EXP_RST_RISES = 3;    // two retry holds plus ERR
`else
  localparam int EXP_TMO_STEPS = 100;
  localparam int EXP_RST_RISES = 1;
`endif

  logic       clkin = 1'b0;
  logic       reset;
  logic       cfg_req;
  logic [5:0] cfg_idsel;
  logic [5:0] cfg_fbdsel;
  logic [5:0] cfg_odsel;
  logic       cfg_ack;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       clk_ready;
  logic       lock_lost;
  logic       pll_error;

  int checks = 0;
  int errors = 0;

  pll_ctrl #(
    .RST_CYCLES  (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(100),
`ifdef PLL_CTRL_RETRY_EN
    .MAX_RETRY   (2),
`endif
    .DEF_IDSEL   (D_ID),
    .DEF_FBDSEL  (D_FB),
    .DEF_ODSEL   (D_OD)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .cfg_req   (cfg_req),
    .cfg_idsel (cfg_idsel),
    .cfg_fbdsel(cfg_fbdsel),
    .cfg_odsel (cfg_odsel),
    .cfg_ack   (cfg_ack),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .pll_idsel (pll_idsel),
    .pll_fbdsel(pll_fbdsel),
    .pll_odsel (pll_odsel),
    .clk_ready (clk_ready),
    .lock_lost (lock_lost),
    .pll_error (pll_error)
  );

  always #5 clkin = ~clkin;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic test_reset;
    reset = 1'b1; cfg_req = 1'b0; pll_lock = 1'b0;
    cfg_idsel = 6'd0; cfg_fbdsel = 6'd0; cfg_odsel = 6'd0;
    step(3);
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL rst_pll_reset: got %b expected 1", pll_reset); end
    checks++; if (clk_ready !== 1'b0) begin errors++; $display("FAIL rst_clk_ready: got %b expected 0", clk_ready); end
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL rst_cfg_ack: got %b expected 0", cfg_ack); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL rst_lock_lost: got %b expected 0", lock_lost); end
    checks++; if (pll_error !== 1'b0) begin errors++; $display("FAIL rst_pll_error: got %b expected 0", pll_error); end
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {D_ID, D_FB, D_OD}) begin
      errors++; $display("FAIL rst_selects: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         pll_idsel, pll_fbdsel, pll_odsel, D_ID, D_FB, D_OD);
    end
  endtask

  task automatic test_powerup;
    int n;
    reset = 1'b0;
    n = 0;
    while (pll_reset === 1'b1 && n < 20) begin n++; step(1); end
    checks++; if (n != 4) begin errors++; $display("FAIL pwr_hold_len: got %0d expected 4", n); end
    step(10);
    pll_lock = 1'b1;
    n = 0;
    while (clk_ready !== 1'b1 && n < 50) begin step(1); n++; end
    checks++; if (n != 11) begin errors++; $display("FAIL pwr_ready_latency: got %0d expected 11", n); end
    checks++; if (pll_reset !== 1'b0) begin errors++; $display("FAIL pwr_ready_reset: got %b expected 0", pll_reset); end
  endtask

  task automatic test_lock_loss;
    int n;
    pll_lock = 1'b0;
    n = 0;
    while (clk_ready === 1'b1 && n < 10) begin step(1); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL loss_latency: got %0d expected 3", n); end
    checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL loss_pulse: got %b expected 1", lock_lost); end
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL loss_hold: got %b expected 1", pll_reset); end
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {D_ID, D_FB, D_OD}) begin
      errors++; $display("FAIL loss_selects: got %0d/%0d/%0d", pll_idsel, pll_fbdsel, pll_odsel);
    end
    step(1);
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL loss_pulse_width: got %b expected 0", lock_lost); end
  endtask

  task automatic test_glitch;
    int n;
    n = 0;
    while (pll_reset === 1'b1 && n < 10) begin step(1); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL glitch_hold_rest: got %0d expected 3", n); end
    pll_lock = 1'b1;
    step(8);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    n = 0;
    while (clk_ready !== 1'b1 && n < 50) begin step(1); n++; end
    checks++; if (n != 11) begin errors++; $display("FAIL glitch_ready_latency: got %0d expected 11", n); end
  endtask

  task automatic test_reconfig;
    int n;
    cfg_req = 1'b1; cfg_idsel = 6'd9; cfg_fbdsel = 6'd3; cfg_odsel = 6'd8;
    step(1);
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL cfg_ack_pulse: got %b expected 1", cfg_ack); end
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'd9, 6'd3, 6'd8}) begin
      errors++; $display("FAIL cfg_selects: got %0d/%0d/%0d expected 9/3/8", pll_idsel, pll_fbdsel, pll_odsel);
    end
    checks++; if (pll_reset !== 1'b0) begin errors++; $display("FAIL cfg_reset_in_ack: got %b expected 0", pll_reset); end
    cfg_req = 1'b0; cfg_idsel = 6'd0; cfg_fbdsel = 6'd0; cfg_odsel = 6'd0;
    step(1);
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL cfg_ack_width: got %b expected 0", cfg_ack); end
    checks++; if (clk_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_drop: got %b expected 0", clk_ready); end
    n = 0;
    while (pll_reset === 1'b1 && n < 20) begin n++; step(1); end
    checks++; if (n != 4) begin errors++; $display("FAIL cfg_hold_len: got %0d expected 4", n); end
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'd9, 6'd3, 6'd8}) begin
      errors++; $display("FAIL cfg_selects_kept: got %0d/%0d/%0d expected 9/3/8", pll_idsel, pll_fbdsel, pll_odsel);
    end
  endtask

  task automatic test_cfg_ignored;
    logic acked;
    acked = 1'b0;
    cfg_req = 1'b1; cfg_idsel = 6'd33; cfg_fbdsel = 6'd34; cfg_odsel = 6'd35;
    for (int i = 0; i < 3; i++) begin step(1); acked = acked | cfg_ack; end
    cfg_req = 1'b0;
    checks++; if (acked !== 1'b0) begin errors++; $display("FAIL ign_ack: got %b expected 0", acked); end
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'd9, 6'd3, 6'd8}) begin
      errors++; $display("FAIL ign_selects: got %0d/%0d/%0d expected 9/3/8", pll_idsel, pll_fbdsel, pll_odsel);
    end
  endtask

  task automatic test_simultaneous;
    int n;
    n = 0;
    while (clk_ready !== 1'b1 && n < 30) begin step(1); n++; end
    checks++; if (clk_ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %b expected 1", clk_ready); end
    pll_lock = 1'b0;
    step(2);
    cfg_req = 1'b1; cfg_idsel = 6'd12; cfg_fbdsel = 6'd5; cfg_odsel = 6'd2;
    step(1);
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL sim_ack: got %b expected 1", cfg_ack); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL sim_no_loss: got %b expected 0", lock_lost); end
    cfg_req = 1'b0;
    step(1);
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL sim_no_late_loss: got %b expected 0", lock_lost); end
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'd12, 6'd5, 6'd2}) begin
      errors++; $display("FAIL sim_selects: got %0d/%0d/%0d expected 12/5/2", pll_idsel, pll_fbdsel, pll_odsel);
    end
  endtask

  task automatic test_timeout;
    int   n;
    int   rises;
    logic prev;
    pll_lock = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    n = 0;
    while (pll_reset === 1'b1 && n < 20) begin step(1); n++; end
    n = 0; rises = 0; prev = pll_reset;
    while (pll_error !== 1'b1 && n < 1000) begin
      step(1); n++;
      if (pll_reset === 1'b1 && prev === 1'b0) rises++;
      prev = pll_reset;
    end
    checks++; if (n != EXP_TMO_STEPS) begin errors++; $display("FAIL tmo_steps: got %0d expected %0d", n, EXP_TMO_STEPS); end
    checks++; if (rises != EXP_RST_RISES) begin errors++; $display("FAIL tmo_reset_rises: got %0d expected %0d", rises, EXP_RST_RISES); end
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL tmo_err_reset: got %b expected 1", pll_reset); end
    step(5);
    checks++; if (pll_error !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", pll_error); end
    cfg_req = 1'b1; cfg_idsel = 6'd7; cfg_fbdsel = 6'd1; cfg_odsel = 6'd2;
    step(1);
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL tmo_ack: got %b expected 1", cfg_ack); end
    checks++; if (pll_error !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", pll_error); end
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL tmo_ack_reset: got %b expected 1", pll_reset); end
    cfg_req = 1'b0;
  endtask

  task automatic test_mid_reset;
    int n;
    pll_lock = 1'b1;
    n = 0;
    while (pll_reset === 1'b1 && n < 20) begin step(1); n++; end
    step(4);
    reset = 1'b1;
    step(1);
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL mid_pll_reset: got %b expected 1", pll_reset); end
    checks++; if ({clk_ready, cfg_ack, lock_lost, pll_error} !== 4'b0000) begin
      errors++; $display("FAIL mid_flags: got %b expected 0000", {clk_ready, cfg_ack, lock_lost, pll_error});
    end
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {D_ID, D_FB, D_OD}) begin
      errors++; $display("FAIL mid_selects: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         pll_idsel, pll_fbdsel, pll_odsel, D_ID, D_FB, D_OD);
    end
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_lock_loss();
    test_glitch();
    test_reconfig();
    test_cfg_ignored();
    test_simultaneous();
    test_timeout();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_ctrl.md
# pll_ctrl

Sequencer for the Gowin rPLL dynamic-configuration port, clocked from the raw 27 MHz crystal clock. It holds the PLL in reset at power-up and on every reconfiguration, drives the IDSEL/FBDSEL/ODSEL dynamic divider selects, and qualifies LOCK with a synchronizer and a stability window. It exports a clean `clk_ready` that gates downstream LCD timing logic. It also detects loss of lock and lock timeout.

## Interface
- `RST_CYCLES`, 16: `pll_reset` hold time in clkin cycles (≥2).
- `LOCK_STABLE`, 1024: consecutive synchronized-lock cycles required before ready.
- `LOCK_TIMEOUT`, 270000: cycles allowed from `pll_reset` release to qualified lock (10 ms @ 27 MHz).
- `MAX_RETRY`, 3: automatic re-reset attempts after a timeout (only with `PLL_CTRL_RETRY_EN`).
- `DEF_IDSEL` / `DEF_FBDSEL` / `DEF_ODSEL`, 6'd0: select codes loaded at reset; passed to the PLL unmodified.

Ports:
- `clkin`  in  1  crystal clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cfg_req`  in  1  level request to apply new selects.
- `cfg_idsel` / `cfg_fbdsel` / `cfg_odsel`  in  6 each  requested codes; sampled on acceptance.
- `cfg_ack`  out  1  one-cycle pulse on acceptance.
- `pll_lock`  in  1  rPLL LOCK; asynchronous to `clkin`.
- `pll_reset`  out  1  to rPLL RESET.
- `pll_idsel` / `pll_fbdsel` / `pll_odsel`  out  6 each  to rPLL IDSEL/FBDSEL/ODSEL; registered.
- `clk_ready`  out  1  PLL output qualified.
- `lock_lost`  out  1  one-cycle pulse when lock drops while ready.
- `pll_error`  out  1  sticky timeout failure; cleared by acceptance of `cfg_req` or by `reset`.

## Operation
- `pll_lock` passes through a 2-FF synchronizer (`lock_s`). All lock decisions use `lock_s`.
- States:
  - **HOLD**: `pll_reset`=1, count `RST_CYCLES`.
  - **WAIT**: `pll_reset`=0, wait for `lock_s`=1.
  - **STAB**: count consecutive `lock_s`=1 cycles.
  - **READY**: `clk_ready`=1.
  - **ERR**: `pll_error`=1, `pll_reset`=1.
- Transitions:
  - HOLD→WAIT when the hold count reaches `RST_CYCLES`. The timeout counter clears on entry to WAIT.
  - WAIT→STAB on `lock_s`=1.
  - STAB→WAIT if `lock_s`=0. The stability counter clears; the timeout counter keeps running.
  - STAB→READY when the stability count reaches `LOCK_STABLE`.
  - WAIT/STAB→timeout when the timeout counter reaches `LOCK_TIMEOUT`. With retry, this goes to HOLD (attempt+1) if attempts < `MAX_RETRY`, else ERR. Without retry, it goes straight to ERR.
  - READY: `lock_s`=0 → `lock_lost` pulse, →HOLD with unchanged selects. The attempt count resets to 0.
  - READY or ERR with `cfg_req`=1 → accept: `cfg_ack` pulse, selects loaded from `cfg_*`, attempt count=0, `pll_error` cleared, →HOLD.
- `cfg_req` in HOLD/WAIT/STAB is not accepted. The requester holds it until `cfg_ack`.
- Counters saturate at their terminal value. Each counter's width is clog2 of its parameter plus 1.
- Reset: state HOLD, selects = `DEF_*`, all counters 0.
  - Output reset values: `pll_reset`=1, `clk_ready`=0, `cfg_ack`=0, `lock_lost`=0, `pll_error`=0.

## Timing
- Lock synchronizer latency: 2 cycles, then 1 cycle to the FSM decision.
- `pll_reset` is high for exactly `RST_CYCLES` cycles after `reset` drops or after acceptance. On acceptance, `pll_reset` rises in the cycle following `cfg_ack`.
- The selects change in the same cycle `cfg_ack` is high, so they are stable ≥`RST_CYCLES` cycles before `pll_reset` falls.
- `clk_ready` rises 1 cycle after the `LOCK_STABLE`-th consecutive `lock_s` cycle.
- `clk_ready` falls in the same cycle `lock_lost` pulses, i.e. 3 cycles after `pll_lock` falls.
- Simultaneous `cfg_req` and `lock_s` drop in READY: `cfg_req` wins. `cfg_ack` pulses, `lock_lost` does not.
- `reset` mid-operation overrides everything on the next edge.

## Configuration
- `PLL_CTRL_RETRY_EN` defined:
  - A timeout re-enters HOLD up to `MAX_RETRY` times before ERR.
- Undefined:
  - The first timeout goes to ERR. The attempt counter and `MAX_RETRY` logic are absent.

## Test plan
All scenarios use `RST_CYCLES`=4, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=100, `MAX_RETRY`=2.
- Power-up: release `reset`; `pll_lock`=1 from 10 cycles after `pll_reset` falls → `pll_reset` high 4 cycles; `clk_ready` rises 8+3 cycles after `pll_lock` rises.
- Glitchy lock: in STAB, drop `pll_lock` for 1 cycle at stability count 5 → count restarts; `clk_ready` rises 11 cycles after `pll_lock` is restored.
- Reconfig: in READY, `cfg_req`=1 with idsel=6'd9, fbdsel=6'd3, odsel=6'd8 → one `cfg_ack`; selects update that cycle; `clk_ready`=0 and `pll_reset`=1 next cycle for 4 cycles.
- Lock loss: in READY, `pll_lock`→0 → `lock_lost` pulse and `clk_ready`=0 3 cycles later; HOLD with unchanged selects.
- Timeout: `pll_lock` held 0 → with macro, 3 HOLD periods then `pll_error`=1; without macro, `pll_error`=1 after the first 100-cycle wait. A subsequent `cfg_req` clears it.
- Mid-sequence reset: assert `reset` during STAB → next cycle all outputs at reset values, selects = `DEF_*`.
